// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default bit periods and the
// transmitter state encoding.
// Optional feature macro: UART_TX_PARITY_EN adds a PARITY state.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // 48 MHz / 9600 Bd for synthesis; a short period for formal/bench.
    localparam int CPB_SYNTH  = 5000;
    localparam int CPB_FORMAL = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;
`endif

    // Counter width for 0..cpb-1, never narrower than one bit.
    function automatic int cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_transmitter_baud_tick_generator.sv
// Bit-period counter for the Tx path: counts 0..CLOCKS_PER_BIT-1 and
// pulses bit_tick on the terminal count.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset
//   clear    in  restart the bit period (frame accept)
//   bit_tick out one-cycle pulse at the last clock of each bit
module baud_tick_generator
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = CPB_SYNTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = cnt_width(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign bit_tick = (count == LAST);

    // Free-running; the accept clears it so the start bit is a full
    // period long regardless of where the counter was while idle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (bit_tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

`ifdef FORMAL
    logic past_valid;

    always_ff @(posedge clk) begin
        past_valid <= 1'b1;
    end

    always @(posedge clk) begin
        assert (count <= LAST);
        if (past_valid && !$past(reset) && !$past(clear)
            && !$past(bit_tick)) begin
            assert (count == $past(count) + CW'(1));
        end
    end
`endif

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per valid/ready handshake, 8N1, LSB
// first, idle-high registered line. With UART_TX_PARITY_EN defined an
// even-parity bit is sent between the data and the stop bit.
// Ports:
//   clk        in  system clock
//   reset      in  synchronous active-high reset
//   tx_data    in  byte to send, latched on accept
//   tx_valid   in  source has a byte
//   tx_ready   out can accept a byte (idle)
//   tx_busy    out frame in progress
//   serial_out out UART Tx line
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = CPB_SYNTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       serial_out
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t state;
    tx_state_t state_next;

    logic [UART_DATA_BITS-1:0] data_q;
    logic [UART_DATA_BITS-1:0] data_next;
    logic [2:0] bit_cnt;
    logic [2:0] bit_next;
    logic       line_next;
    logic       accept;
    logic       bit_tick;

    assign tx_ready = (state == TX_IDLE);
    assign tx_busy  = ~tx_ready;
    assign accept   = tx_valid && tx_ready;

    baud_tick_generator #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= TX_IDLE;
            data_q     <= '0;
            bit_cnt    <= '0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_next;
            data_q     <= data_next;
            bit_cnt    <= bit_next;
            serial_out <= line_next;
        end
    end

    always_comb begin
        state_next = state;
        data_next  = data_q;
        bit_next   = bit_cnt;
        unique case (state)
            TX_IDLE: begin
                if (tx_valid) begin
                    state_next = TX_START;
                    data_next  = tx_data;
                    bit_next   = '0;
                end
            end
            TX_START: begin
                if (bit_tick) begin
                    state_next = TX_DATA;
                    bit_next   = '0;
                end
            end
            TX_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next = TX_PARITY;
`else
                        state_next = TX_STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_tick) begin
                    state_next = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (bit_tick) begin
                    state_next = TX_IDLE;
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so the output register
    // only moves on accept or bit boundaries.
    always_comb begin
        line_next = 1'b1;
        unique case (state_next)
            TX_START: line_next = 1'b0;
            TX_DATA:  line_next = data_next[bit_next];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: line_next = ^data_next;
`endif
            default:  line_next = 1'b1;
        endcase
    end

`ifdef FORMAL
    always @(posedge clk) begin
        assert (tx_ready == (state == TX_IDLE));
        if (state == TX_IDLE || state == TX_STOP) begin
            assert (serial_out == 1'b1);
        end
    end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter with CLOCKS_PER_BIT=8:
// cycle-exact line checks plus an Rx-style mid-bit decoder scoreboard.
module tb_uart_transmitter;

    localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       serial_out;

    int checks = 0;
    int failures = 0;
    int rx_frames = 0;
    bit abort = 1'b0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLOCKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .serial_out(serial_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Required line level for frame cycle c (1-based) of byte d.
    function automatic logic exp_line(input logic [7:0] d, input int c);
        int b;
        b = (c - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge with tx_valid/tx_data already driven.
    task automatic run_frame(input logic [7:0] d, input bit hold,
                             input int chg_c, input logic [7:0] chg_v);
        sb.push_back(d);
        chk("pre_ready", tx_ready, 1);
        @(posedge clk);
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (!hold && c == 1) tx_valid = 1'b0;
            if (c == chg_c) tx_data = chg_v;
            chk($sformatf("line_%02h_c%0d", d, c), serial_out,
                exp_line(d, c));
            chk($sformatf("busy_%02h_c%0d", d, c),
                {tx_ready, tx_busy}, 2'b01);
        end
        @(negedge clk);
        chk($sformatf("ready_%02h_end", d), tx_ready, 1);
        chk($sformatf("idle_line_%02h", d), serial_out, 1);
    endtask

    // Rx-side decoder: samples at bit midpoints and scores bytes.
    initial begin
        logic [7:0] rx;
        forever begin
            @(negedge clk);
            if (serial_out === 1'b0 && reset === 1'b0) begin
                repeat (CPB / 2 - 1) @(negedge clk);
                chk("rx_start", serial_out, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx[i] = serial_out;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                if (!abort) chk("rx_parity", serial_out, ^rx);
`endif
                repeat (CPB) @(negedge clk);
                if (abort) begin
                    abort = 1'b0;
                end else begin
                    chk("rx_stop", serial_out, 1);
                    checks++;
                    assert (sb.size() > 0) else begin
                        failures++;
                        $error("FAIL rx_spurious observed=%0h expected=none",
                               rx);
                    end
                    if (sb.size() > 0) begin
                        chk("rx_byte", rx, sb.pop_front());
                        rx_frames++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_line", serial_out, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_line", serial_out, 1);

        tx_data = 8'hA5;
        tx_valid = 1'b1;
        run_frame(8'hA5, 1'b0, 0, 8'h00);

        repeat (3) @(negedge clk);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        run_frame(8'h00, 1'b1, 1, 8'hFF);
        run_frame(8'hFF, 1'b0, 0, 8'h00);

        repeat (2) @(negedge clk);
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        run_frame(8'h3C, 1'b0, 2, 8'hC3);

        // Abort during data bit 2 of an all-zero byte.
        repeat (2) @(negedge clk);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (29) @(negedge clk);
        chk("mid_line_c30", serial_out, 0);
        abort = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_line", serial_out, 1);
        chk("abort_ready", tx_ready, 1);
        chk("abort_busy", tx_busy, 0);
        reset = 1'b0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            chk($sformatf("idle_hold_%0d", i), {serial_out, tx_ready},
                2'b11);
        end
        tx_data = 8'h55;
        tx_valid = 1'b1;
        run_frame(8'h55, 1'b0, 0, 8'h00);

        tx_data = 8'h00;
        tx_valid = 1'b1;
        run_frame(8'h00, 1'b0, 0, 8'h00);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        run_frame(8'hFF, 1'b0, 0, 8'h00);
        tx_data = 8'h81;
        tx_valid = 1'b1;
        run_frame(8'h81, 1'b0, 0, 8'h00);
        tx_data = 8'h07;
        tx_valid = 1'b1;
        run_frame(8'h07, 1'b0, 0, 8'h00);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb.size(), 0);
        chk("rx_frames", rx_frames, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises one byte per handshake onto the UART Tx line: 8N1 framing, LSB first.
- Idle level is high.
- Uses the same bit period (CLOCKS_PER_BIT system clocks) as the Rx path, so the Rx sampling strobe lands mid-bit on frames this block produces.
- Sits between the user-side byte source and the Tx pin.

Parameters:
- CLOCKS_PER_BIT, 5000: system clocks per UART bit (48 MHz / 9600 Bd). The formal and bench build uses 8.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on an accepted handshake.
- tx_valid  input  1  source has a byte available.
- tx_ready  output  1  block can accept a byte this cycle (high only in IDLE).
- tx_busy  output  1  frame in progress (inverse of tx_ready).
- serial_out  output  1  UART Tx line, registered.

Behaviour:
- Reset values: serial_out=1, tx_ready=1, tx_busy=0, state=IDLE, bit counter=0, clock counter=0.
- Reset takes priority over everything. A reset mid-frame aborts the frame: serial_out=1 from the next edge, with no partial stop bit.
- Accept occurs when tx_valid && tx_ready at a rising edge (call it cycle 0):
  - tx_data is latched into the shift register.
  - tx_data changes after cycle 0 have no effect on the frame.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: serial_out=1; on accept go to START.
  - START: serial_out=0 for cycles 1..CLOCKS_PER_BIT.
  - DATA: bit i (i=0..7, LSB first) is driven for CLOCKS_PER_BIT cycles each, cycles (i+1)*CPB+1 .. (i+2)*CPB.
  - STOP: serial_out=1 for cycles 9*CPB+1 .. 10*CPB.
  - Return to IDLE: tx_ready=1 at cycle 10*CPB+1.
- Frame and throughput:
  - The frame is exactly 10*CLOCKS_PER_BIT cycles long.
  - Minimum accept-to-accept spacing is 10*CLOCKS_PER_BIT+1 cycles.
- Clock counter:
  - Width $clog2(CLOCKS_PER_BIT), counts 0..CLOCKS_PER_BIT-1.
  - Wraps to 0 and advances the bit on the CLOCKS_PER_BIT-1 terminal count.
  - Never exceeds CLOCKS_PER_BIT-1.
- Bit counter: 3 bits. Leaves DATA when bit 7's period completes.
- Edge cases:
  - tx_valid held high continuously: accepted again in the first IDLE cycle.
  - tx_valid low in IDLE: the line stays 1 indefinitely.
- Glitch-free line: serial_out changes only at bit boundaries.
- Formal properties (under FORMAL):
  - Clock counter < CLOCKS_PER_BIT.
  - tx_ready == (state==IDLE).
  - serial_out==1 whenever in IDLE or STOP.
  - Clock counter increments by 1 unless it wrapped or the cycle was an accept.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 latched data bits) for CLOCKS_PER_BIT cycles.
  - The frame becomes 11*CLOCKS_PER_BIT cycles and tx_ready returns at cycle 11*CPB+1.
- Undefined: 8N1 exactly as above. No parity logic or state encoding is present.

Decomposition:
- Shared package uart_pkg:
  - Tx state encoding (IDLE, START, DATA, PARITY, STOP).
  - UART_DATA_BITS=8.
  - Default CLOCKS_PER_BIT values for synthesis and formal.
- Sub-module baud_tick_generator:
  - Free-running within a frame.
  - Counts 0..CLOCKS_PER_BIT-1 and pulses bit_tick for one cycle on terminal count.
  - Cleared to 0 on the accept cycle and on reset.
  - This is the Tx-side counterpart to the Rx sampling strobe logic.

Test Plan (CLOCKS_PER_BIT=8):
- Single byte: reset, then accept 0xA5 at cycle 0. Required response:
  - serial_out=0 for cycles 1-8.
  - Then bits 1,0,1,0,0,1,0,1 at 8 cycles each.
  - Stop=1 for cycles 73-80.
  - tx_ready=1 at cycle 81.
- Back-to-back: tx_valid held high with 0x00 then 0xFF. Required response:
  - The second accept occurs at cycle 81.
  - Its start bit spans cycles 82-89.
  - The line is never low during the first frame's stop bit.
- Data stability: accept 0x3C, then change tx_data to 0xC3 at cycle 2. The transmitted bits still decode as 0x3C.
- Reset mid-frame: assert reset at cycle 30 during data bit 2. Required response:
  - serial_out=1 and tx_ready=1 from cycle 31.
  - A new accept of 0x55 then produces a clean full frame.
- Loopback: serial_out is wired to the Rx path and 0x00, 0xFF, 0x81 are sent. Every Rx sampling strobe falls at bit midpoints and all three bytes are received correctly.
- UART_TX_PARITY_EN: accept 0x07 (three ones). Required response:
  - Parity bit=1 for cycles 73-80.
  - Stop for cycles 81-88.
  - tx_ready at cycle 89.
